// File: rtl/result_formatter_if.sv
// Signal bundle between a detection source / UART transmitter and the result formatter.
// detValid is a one-cycle pulse with no ready: it is accepted only when busy is low,
// otherwise it is dropped. txStart is a level request held until txDone is sampled high.
interface result_formatter_if #(
    parameter int W = 10
);
    logic         detValid;
    logic [2:0]   imageIDIn;
    logic         resultIn;
    logic [W-1:0] accIn;
    logic [W-1:0] x1In;
    logic [W-1:0] x2In;
    logic [W-1:0] y1In;
    logic [W-1:0] y2In;
    logic         txDone;

    logic         txStart;
    logic         txReset;
    logic [2:0]   imageID;
    logic         result;
    logic [3:0]   acc_1, acc_2, acc_3;
    logic [3:0]   bb1_1, bb1_2, bb1_3, bb1_4, bb1_5, bb1_6;
    logic [3:0]   bb2_1, bb2_2, bb2_3, bb2_4, bb2_5, bb2_6;
    logic         busy;
    logic         dropped;
    logic [1:0]   dbg_state;

    modport master (
        output detValid, imageIDIn, resultIn, accIn, x1In, x2In, y1In, y2In, txDone,
        input  txStart, txReset, imageID, result, acc_1, acc_2, acc_3,
        input  bb1_1, bb1_2, bb1_3, bb1_4, bb1_5, bb1_6,
        input  bb2_1, bb2_2, bb2_3, bb2_4, bb2_5, bb2_6,
        input  busy, dropped, dbg_state
    );

    modport slave (
        input  detValid, imageIDIn, resultIn, accIn, x1In, x2In, y1In, y2In, txDone,
        output txStart, txReset, imageID, result, acc_1, acc_2, acc_3,
        output bb1_1, bb1_2, bb1_3, bb1_4, bb1_5, bb1_6,
        output bb2_1, bb2_2, bb2_3, bb2_4, bb2_5, bb2_6,
        output busy, dropped, dbg_state
    );
endinterface

// File: rtl/result_formatter.sv
// Captures one detection result, converts five saturated values to 3-digit BCD with a
// single shared double-dabble unit, then hands the frame to a UART and clears it.
module result_formatter #(
    parameter int W    = 10,
    parameter int MAXV = 999
) (
    input  logic              clk,
    input  logic              reset,
    result_formatter_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, CONV = 2'd1, SEND = 2'd2, CLEAR = 2'd3} state_t;

    localparam int            CW       = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);
    localparam logic [W-1:0]  MAXV_W   = W'(MAXV);

    function automatic logic [W-1:0] sat(input logic [W-1:0] v);
        return (v > MAXV_W) ? MAXV_W : v;
    endfunction

    function automatic logic [11:0] add3(input logic [11:0] d);
        logic [11:0] r;
        r = d;
        for (int i = 0; i < 3; i++) begin
            if (d[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = d[i*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

    state_t         state, state_nx;
    logic [W-1:0]   h_x1, h_x2, h_y1, h_y2;
    logic [2:0]     h_id;
    logic           h_res;
    logic [W-1:0]   bin_sr;
    logic [11:0]    bcd_sr;
    logic [CW-1:0]  bit_cnt;
    logic [2:0]     val_idx;
    logic [11:0]    stage [4];
    logic [11:0]    d_acc, d_x1, d_x2, d_y1, d_y2;
    logic [2:0]     id_q;
    logic           res_q;
    logic           dropped_q;

    logic [11+W:0]  shifted;
    logic [11:0]    new_bcd;
    logic [W-1:0]   new_bin;
    logic [W-1:0]   next_val;
    logic           word_done;

    // Correct every nibble, then shift the concatenated BCD/binary word by one.
    always_comb begin
        shifted   = {add3(bcd_sr), bin_sr} << 1;
        new_bcd   = shifted[11+W:W];
        new_bin   = shifted[W-1:0];
        word_done = (bit_cnt == LAST_BIT);
        case (val_idx)
            3'd0:    next_val = h_x1;
            3'd1:    next_val = h_x2;
            3'd2:    next_val = h_y1;
            3'd3:    next_val = h_y2;
            default: next_val = '0;
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.detValid) state_nx = CONV;
            CONV:    if (word_done && val_idx == 3'd4) state_nx = SEND;
            SEND:    if (bus.txDone) state_nx = CLEAR;
            CLEAR:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_x1 <= '0; h_x2 <= '0; h_y1 <= '0; h_y2 <= '0;
            h_id <= '0; h_res <= 1'b0;
            bin_sr <= '0; bcd_sr <= '0; bit_cnt <= '0; val_idx <= '0;
            for (int i = 0; i < 4; i++) stage[i] <= '0;
            d_acc <= '0; d_x1 <= '0; d_x2 <= '0; d_y1 <= '0; d_y2 <= '0;
            id_q <= '0; res_q <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            if (bus.detValid && state != IDLE) dropped_q <= 1'b1;
            case (state)
                IDLE: begin
                    if (bus.detValid) begin
                        h_x1    <= sat(bus.x1In);
                        h_x2    <= sat(bus.x2In);
                        h_y1    <= sat(bus.y1In);
                        h_y2    <= sat(bus.y2In);
                        h_id    <= bus.imageIDIn;
                        h_res   <= bus.resultIn;
                        bin_sr  <= sat(bus.accIn);
                        bcd_sr  <= '0;
                        bit_cnt <= '0;
                        val_idx <= '0;
                    end
                end
                CONV: begin
                    if (word_done) begin
                        bin_sr  <= next_val;
                        bcd_sr  <= '0;
                        bit_cnt <= '0;
                        val_idx <= val_idx + 3'd1;
                        if (val_idx != 3'd4) begin
                            stage[val_idx[1:0]] <= new_bcd;
                        end else begin
                            // Whole frame becomes visible at once on entry to SEND.
                            d_acc <= stage[0];
                            d_x1  <= stage[1];
                            d_x2  <= stage[2];
                            d_y1  <= stage[3];
                            d_y2  <= new_bcd;
                            id_q  <= h_id;
                            res_q <= h_res;
                        end
                    end else begin
                        bin_sr  <= new_bin;
                        bcd_sr  <= new_bcd;
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.txStart   = (state == SEND);
    assign bus.txReset   = (state == CLEAR);
    assign bus.busy      = (state != IDLE);
    assign bus.dropped   = dropped_q;
    assign bus.dbg_state = state;
    assign bus.imageID   = id_q;
    assign bus.result    = res_q;

    assign {bus.acc_1, bus.acc_2, bus.acc_3} = d_acc;
    assign {bus.bb1_1, bus.bb1_2, bus.bb1_3} = d_x1;
    assign {bus.bb1_4, bus.bb1_5, bus.bb1_6} = d_x2;
    assign {bus.bb2_1, bus.bb2_2, bus.bb2_3} = d_y1;
    assign {bus.bb2_4, bus.bb2_5, bus.bb2_6} = d_y2;
endmodule

// File: doc/result_formatter.md
RESULT_FORMATTER -- requirements
Module: result_formatter

Interface
REQ-001 Parameter W, default 10: bit width of each binary input value.
REQ-002 Parameter MAXV, default 999: saturation limit; each value converts to exactly 3 BCD digits.
REQ-003 clk  input  1  single clock; all registers on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset: 0 resets immediately, independent of clk.
REQ-005 detValid  input  1  one-cycle pulse; detection result inputs valid this cycle.
REQ-006 imageIDIn  input  3  image identifier.
REQ-007 resultIn  input  1  detection class/result bit.
REQ-008 accIn  input  W  accuracy in tenths of a percent (0..999 = 0.0..99.9).
REQ-009 x1In, x2In, y1In, y2In  input  W each  bounding-box coordinates.
REQ-010 txDone  input  1  done flag from the downstream UART transmitter; sticky until that transmitter is reset.
REQ-011 txStart  output  1  request to the UART to transmit the held frame.
REQ-012 txReset  output  1  active-high one-cycle pulse that clears the UART (and its txDone).
REQ-013 imageID, result  output  3, 1  held copies of imageIDIn and resultIn.
REQ-014 acc_1..acc_3  output  4 each  accuracy BCD digits, hundreds..units.
REQ-015 bb1_1..bb1_6  output  4 each  x1 digits (bb1_1..3, hundreds..units), then x2 digits (bb1_4..6).
REQ-016 bb2_1..bb2_6  output  4 each  y1 digits (bb2_1..3), then y2 digits (bb2_4..6).
REQ-017 busy  output  1  high whenever the state is not IDLE.
REQ-018 dropped  output  1  sticky; set when a detValid pulse is ignored.

Function
REQ-019 The block SHALL use the states IDLE, CONV, SEND and CLEAR.
REQ-020 In IDLE, detValid=1 SHALL capture all inputs into holding registers and enter CONV on the next edge.
REQ-021 At capture, any value > MAXV SHALL saturate to MAXV.
REQ-022 CONV SHALL convert the five values in the fixed order acc, x1, x2, y1, y2.
- One shared sequential shift-add-3 (double-dabble) unit.
- One shift per clock; W shifts per value.
- 5*W cycles total (50 at default).
REQ-023 Digit outputs and imageID/result SHALL update together, only on the CONV->SEND edge, and SHALL stay stable through SEND and CLEAR.
REQ-024 SEND SHALL drive txStart=1 and hold it until txDone=1 is sampled.
REQ-025 On sampling txDone=1 in SEND, the block SHALL enter CLEAR.
REQ-026 CLEAR SHALL last exactly one cycle, with txStart=0 and txReset=1, and SHALL then return to IDLE.
REQ-027 Latency SHALL be 5*W+1 edges from the detValid edge to txStart=1 (51 at default).
REQ-028 detValid=1 in any state other than IDLE SHALL be ignored and SHALL set dropped.
REQ-029 dropped SHALL clear only on reset.
REQ-030 detValid=1 in the same cycle as the CLEAR->IDLE transition SHALL be ignored and SHALL set dropped.
REQ-031 txDone=1 while in IDLE or CONV SHALL be ignored.
REQ-032 The BCD add-3 correction SHALL be applied to a nibble only when that nibble is >= 5, before each shift.
- Digits SHALL never exceed 9.
REQ-033 A value of 0 SHALL produce digits 0,0,0.

Reset
REQ-034 While reset=0, the block SHALL be in IDLE and all outputs (txStart, txReset, busy, dropped, every digit, imageID, result) SHALL be 0.
REQ-035 The conversion shift registers and counters SHALL also be 0 during reset.
REQ-036 Reset asserted mid-CONV or mid-SEND SHALL abort immediately, with txStart=0 in the same cycle.
REQ-037 After reset deasserts, the block SHALL accept a new detValid on the first edge.

Verification
REQ-038 Nominal frame: acc=978, x1=213, x2=231, y1=345, y2=322, imageID=2, result=1.
- Required: txStart at edge 51.
- Digits 9,7,8 / 2,1,3,2,3,1 / 3,4,5,3,2,2.
REQ-039 Saturation: acc=1023, x1=0 -> acc digits 9,9,9; x1 digits 0,0,0.
REQ-040 Handshake: txDone raised 100 cycles after txStart.
- Required: txStart holds for those 100 cycles.
- Next cycle: txStart=0, txReset=1 for one cycle.
- Then busy=0.
REQ-041 Drop: second detValid pulse at cycle 10 of CONV.
- Required: digits from the first frame only; dropped=1.
REQ-042 Async reset at cycle 30 of CONV, with no clock edge during the reset pulse.
- Required: all outputs 0 immediately.
- A new frame afterwards converts correctly.
REQ-043 Spurious txDone=1 during IDLE and CONV -> no state change; txReset stays 0.
